// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus an independent per-bit debouncer
// for the slide switches. A bit's debounced level changes only after its
// synchronised value has disagreed with it for STABLE_COUNT consecutive
// cycles. The change is reported with a one-cycle rise or fall strobe.
// No output has a combinational path from SW_raw.
module sw_debounce #(
  parameter  int WIDTH        = 10,
  parameter  int STABLE_COUNT = 3,
  localparam int CW           = $clog2(STABLE_COUNT + 1)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] SW_raw,
  output logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_rise,
  output logic [WIDTH-1:0] SW_fall
);

  if (STABLE_COUNT < 1) begin : g_bad_stable_count
    $error("sw_debounce: STABLE_COUNT must be >= 1");
  end

  // STABLE: the synchronised input agrees with SW.
  // PENDING: the synchronised input disagrees with SW and is being timed.
  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } deb_state_e;

  // Count value at which a pending change is accepted on the next edge.
  localparam logic [CW-1:0] LAST = CW'(STABLE_COUNT - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  deb_state_e       state [WIDTH];
  logic [WIDTH-1:0] sw_d;
  logic [WIDTH-1:0] rise_d;
  logic [WIDTH-1:0] fall_d;

  // Per-bit state decode, counter update and accept/strobe decision.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      state[i]  = (sync2[i] != SW[i]) ? PENDING : STABLE;
      cnt_d[i]  = '0;
      sw_d[i]   = SW[i];
      rise_d[i] = 1'b0;
      fall_d[i] = 1'b0;
      case (state[i])
        PENDING: begin
          if (cnt_q[i] == LAST) begin
            // The disagreement has lasted long enough, so accept the new level.
            sw_d[i]   = sync2[i];
            rise_d[i] = sync2[i];
            fall_d[i] = ~sync2[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          // The input agrees with SW again. Any partial count is dropped here,
          // which is how a glitch gets rejected.
          cnt_d[i] = '0;
        end
      endcase
    end
  end

  // Synchroniser chain, per-bit counters and registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync1   <= '0;
      sync2   <= '0;
      SW      <= '0;
      SW_rise <= '0;
      SW_fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1   <= SW_raw;
      sync2   <= sync1;
      SW      <= sw_d;
      SW_rise <= rise_d;
      SW_fall <= fall_d;
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce: drives directed switch scenarios followed by random
// activity into two instances of sw_debounce, one with STABLE_COUNT=3 and
// one with STABLE_COUNT=1. Each instance is compared against a reference
// model. The model keeps a short history of the synchronised input and
// accepts a bit once the last STABLE_COUNT entries all disagree with the
// current debounced level.
module tb_sw_debounce;
  localparam int W = 10;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] raw = '0;
  always #5 clk = ~clk;

  logic [W-1:0] sw3, rise3, fall3;
  logic [W-1:0] sw1, rise1, fall1;

  sw_debounce #(.WIDTH(W), .STABLE_COUNT(3)) u3 (
    .Clock(clk), .Reset(rst), .SW_raw(raw),
    .SW(sw3), .SW_rise(rise3), .SW_fall(fall3)
  );

  sw_debounce #(.WIDTH(W), .STABLE_COUNT(1)) u1 (
    .Clock(clk), .Reset(rst), .SW_raw(raw),
    .SW(sw1), .SW_rise(rise1), .SW_fall(fall1)
  );

  // ---------------- scoreboard / checker ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_s1 = '0, m_s2 = '0;
  logic [W-1:0] m_sw3 = '0, m_r3 = '0, m_f3 = '0;
  logic [W-1:0] m_sw1 = '0, m_r1 = '0, m_f1 = '0;
  logic [W-1:0] hq[$];   // synchronised input seen at recent edges, oldest first
  logic [W-1:0] acc3, acc1;

  // Bits whose last sc history entries all differ from the debounced level.
  function automatic logic [W-1:0] accept(input int sc, input logic [W-1:0] swv);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < W; i++) begin
      logic ok;
      ok = (hq.size() >= sc);
      for (int k = 0; k < sc && ok; k++) begin
        if (hq[hq.size() - 1 - k][i] == swv[i]) ok = 1'b0;
      end
      m[i] = ok;
    end
    return m;
  endfunction

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_s1 = '0; m_s2 = '0; hq.delete();
        m_sw3 = '0; m_r3 = '0; m_f3 = '0;
        m_sw1 = '0; m_r1 = '0; m_f1 = '0;
      end else begin
        hq.push_back(m_s2);
        if (hq.size() > 3) void'(hq.pop_front());
        acc3 = accept(3, m_sw3);
        acc1 = accept(1, m_sw1);
        m_r3 = acc3 & ~m_sw3;  m_f3 = acc3 & m_sw3;  m_sw3 = m_sw3 ^ acc3;
        m_r1 = acc1 & ~m_sw1;  m_f1 = acc1 & m_sw1;  m_sw1 = m_sw1 ^ acc1;
        m_s2 = m_s1;
        m_s1 = raw;
      end
    end
  end

  task automatic compare_all();
    chk("sw3",   16'(sw3),   16'(m_sw3));
    chk("rise3", 16'(rise3), 16'(m_r3));
    chk("fall3", 16'(fall3), 16'(m_f3));
    chk("both3", 16'(rise3 & fall3), 16'h0);
    chk("sw1",   16'(sw1),   16'(m_sw1));
    chk("rise1", 16'(rise1), 16'(m_r1));
    chk("fall1", 16'(fall1), 16'(m_f1));
    chk("both1", 16'(rise1 & fall1), 16'h0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sw3"},   16'(sw3),   16'h0);
    chk({tag, "_rise3"}, 16'(rise3), 16'h0);
    chk({tag, "_fall3"}, 16'(fall3), 16'h0);
    chk({tag, "_sw1"},   16'(sw1),   16'h0);
    chk({tag, "_rise1"}, 16'(rise1), 16'h0);
    chk({tag, "_fall1"}, 16'(fall1), 16'h0);
  endtask

  // ---------------- driver tasks ----------------
  // One cycle: wait for the falling edge, then compare against the model.
  task automatic tick();
    @(negedge clk);
    compare_all();
  endtask

  task automatic hold(input logic [W-1:0] v, input int n);
    raw = v;
    repeat (n) tick();
  endtask

  int lat3, lat1, cnt, nrise;
  logic [W-1:0] rval;
  logic [W-1:0] mask;
  logic [8:0]   bounce;

  initial begin
    // Asynchronous reset with every switch high, checked before any clock edge.
    #1;
    raw = 10'h3FF;
    rst = 1'b1;
    #1;
    check_zero("rst_async");
    repeat (2) tick();
    rst = 1'b0;

    // Latency after release: the change lands on edge STABLE_COUNT+2,
    // counting the first edge after release as edge 1.
    lat3 = 0; lat1 = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (lat3 == 0 && sw3 == 10'h3FF) lat3 = n;
      if (lat1 == 0 && sw1 == 10'h3FF) lat1 = n;
    end
    chk("rst_lat3", 16'(lat3), 16'd5);
    chk("rst_lat1", 16'(lat1), 16'd3);

    // Clean toggle of SW8.
    hold(10'h000, 8);
    hold(10'h100, 8);
    hold(10'h000, 8);

    // Glitches on SW3: a 2-cycle pulse is rejected, a 3-cycle pulse is accepted.
    hold(10'h008, 2);
    hold(10'h000, 8);
    hold(10'h008, 3);
    hold(10'h000, 10);

    // Bounce on SW0: exactly one accepted rise at STABLE_COUNT=3.
    bounce = 9'b111101101;  // bit 0 is applied first
    nrise = 0;
    for (int k = 0; k < 9; k++) begin
      raw = {9'h0, bounce[k]};
      tick();
      if (rise3[0]) nrise++;
    end
    raw = 10'h001;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rise3[0]) nrise++;
    end
    chk("bounce_rises3", 16'(nrise), 16'd1);

    // Simultaneous change on several bits.
    hold(10'h000, 8);
    raw = 10'h2A5;
    cnt = 0; rval = '0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (rise3 != '0) begin cnt++; rval = rise3; end
    end
    chk("multi_n3",   16'(cnt),  16'd1);
    chk("multi_val3", 16'(rval), 16'h2A5);
    chk("multi_sw3",  16'(sw3),  16'h2A5);

    // Reset while SW5 is pending.
    hold(10'h000, 8);
    raw = 10'h020;
    repeat (3) tick();
    #2 rst = 1'b1;
    #1 check_zero("rst_mid");
    repeat (2) tick();
    rst = 1'b0;
    lat3 = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (lat3 == 0 && sw3[5]) lat3 = n;
    end
    chk("rst_mid_lat3", 16'(lat3), 16'd5);

    // Random activity with occasional asynchronous reset pulses.
    for (int c = 0; c < 900; c++) begin
      mask = '0;
      for (int i = 0; i < W; i++) mask[i] = ($urandom_range(0, 5) == 0);
      raw = raw ^ mask;
      if ($urandom_range(0, 299) == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
